// File: rtl/bullet_scheduler.sv
// Shared bullet pool: round-robin fire arbitration (one grant per frame), slot allocation and per-frame motion.
// Build option OWNER_LIMIT_EN: a tank that already owns a live bullet cannot fire again.
module bullet_scheduler #(
   parameter int NREQ     = 4,
   parameter int NSLOT    = 8,
   parameter int SPEED    = 2,
   parameter int COOLDOWN = 30,
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479
) (
   input  logic                  frame_clk,
   input  logic                  Reset,
   input  logic [NREQ-1:0]       fire_req,
   input  logic [10*NREQ-1:0]    fire_x,
   input  logic [10*NREQ-1:0]    fire_y,
   input  logic [2*NREQ-1:0]     fire_dir,
   input  logic [NSLOT-1:0]      slot_kill,
   output logic [NREQ-1:0]       fire_grant,
   output logic [NREQ-1:0]       fire_drop,
   output logic [NSLOT-1:0]      slot_active,
   output logic [10*NSLOT-1:0]   slot_x,
   output logic [10*NSLOT-1:0]   slot_y,
   output logic [2*NSLOT-1:0]    slot_dir,
   output logic [2*NSLOT-1:0]    slot_owner
);
   localparam int CW = $clog2(COOLDOWN + 2);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
   localparam logic [10:0]   SPD     = 11'(SPEED);
   localparam logic [10:0]   XLIM    = 11'(X_MAX);
   localparam logic [10:0]   YLIM    = 11'(Y_MAX);

   logic [CW-1:0]        cooldown [NREQ];
   logic [PW-1:0]        rr_ptr;
   logic [NREQ-1:0]      eligible;
   logic                 win_found;
   int                   win_i;
   logic [9:0]           win_x, win_y;
   logic [1:0]           win_dir;
   logic                 free_found;
   int                   free_i;
   logic [NSLOT-1:0]     slot_alive;
   logic [10*NSLOT-1:0]  mv_x, mv_y;

`ifdef OWNER_LIMIT_EN
   logic [NREQ-1:0]      owns;

   always_comb begin
      owns = '0;
      for (int i = 0; i < NREQ; i++)
         for (int s = 0; s < NSLOT; s++)
            if (slot_active[s] && slot_owner[2*s+:2] == 2'(i))
               owns[i] = 1'b1;
   end

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++)
         eligible[i] = fire_req[i] && (cooldown[i] == '0) && !owns[i];
   end
`else
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NREQ; i++)
         eligible[i] = fire_req[i] && (cooldown[i] == '0);
   end
`endif

   // first eligible requester scanning upward from rr_ptr
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_i     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!win_found && eligible[idx]) begin
            win_found = 1'b1;
            win_i     = idx;
         end
      end
   end

   always_comb begin
      win_x   = '0;
      win_y   = '0;
      win_dir = '0;
      for (int i = 0; i < NREQ; i++)
         if (i == win_i) begin
            win_x   = fire_x[10*i+:10];
            win_y   = fire_y[10*i+:10];
            win_dir = fire_dir[2*i+:2];
         end
   end

   // lowest free slot, judged on the registered vector only
   always_comb begin
      free_found = 1'b0;
      free_i     = 0;
      for (int s = NSLOT-1; s >= 0; s--)
         if (!slot_active[s]) begin
            free_found = 1'b1;
            free_i     = s;
         end
   end

   always_comb begin
      logic [10:0] px, py;
      px         = '0;
      py         = '0;
      slot_alive = slot_active;
      mv_x       = slot_x;
      mv_y       = slot_y;
      for (int s = 0; s < NSLOT; s++) begin
         px = {1'b0, slot_x[10*s+:10]};
         py = {1'b0, slot_y[10*s+:10]};
         if (slot_active[s]) begin
            if (slot_kill[s])
               slot_alive[s] = 1'b0;
            else begin
               case (slot_dir[2*s+:2])
                  2'd0: if (py < SPD) slot_alive[s] = 1'b0;
                        else mv_y[10*s+:10] = 10'(py - SPD);
                  2'd1: if (py + SPD > YLIM) slot_alive[s] = 1'b0;
                        else mv_y[10*s+:10] = 10'(py + SPD);
                  2'd2: if (px < SPD) slot_alive[s] = 1'b0;
                        else mv_x[10*s+:10] = 10'(px - SPD);
                  default: if (px + SPD > XLIM) slot_alive[s] = 1'b0;
                           else mv_x[10*s+:10] = 10'(px + SPD);
               endcase
            end
         end
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         fire_grant  <= '0;
         fire_drop   <= '0;
         slot_active <= '0;
         slot_x      <= '0;
         slot_y      <= '0;
         slot_dir    <= '0;
         slot_owner  <= '0;
         rr_ptr      <= '0;
         for (int i = 0; i < NREQ; i++)
            cooldown[i] <= '0;
      end else begin
         fire_grant  <= '0;
         fire_drop   <= '0;
         slot_active <= slot_alive;
         slot_x      <= mv_x;
         slot_y      <= mv_y;
         for (int i = 0; i < NREQ; i++)
            if (cooldown[i] != '0)
               cooldown[i] <= cooldown[i] - 1'b1;

         if (win_found && free_found) begin
            for (int s = 0; s < NSLOT; s++)
               if (s == free_i) begin
                  slot_active[s]      <= 1'b1;
                  slot_x[10*s+:10]    <= win_x;
                  slot_y[10*s+:10]    <= win_y;
                  slot_dir[2*s+:2]    <= win_dir;
                  slot_owner[2*s+:2]  <= 2'(win_i);
               end
            for (int i = 0; i < NREQ; i++)
               if (i == win_i) begin
                  fire_grant[i] <= 1'b1;
                  cooldown[i]   <= CD_LOAD;
               end
            rr_ptr <= PW'((win_i + 1) % NREQ);
         end else if (win_found) begin
            for (int i = 0; i < NREQ; i++)
               if (i == win_i)
                  fire_drop[i] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: arbitration order, cooldown, pool-full drop, motion and retirement.
module tb_bullet_scheduler;
   localparam int NREQ  = 4;
   localparam int NSLOT = 8;

   logic                 frame_clk = 1'b0;
   logic                 Reset     = 1'b1;
   logic [NREQ-1:0]      fire_req;
   logic [10*NREQ-1:0]   fire_x, fire_y;
   logic [2*NREQ-1:0]    fire_dir;
   logic [NSLOT-1:0]     slot_kill;
   logic [NREQ-1:0]      fire_grant, fire_drop;
   logic [NSLOT-1:0]     slot_active;
   logic [10*NSLOT-1:0]  slot_x, slot_y;
   logic [2*NSLOT-1:0]   slot_dir, slot_owner;

   int n_chk = 0;
   int n_err = 0;

   bullet_scheduler dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .fire_req   (fire_req),
      .fire_x     (fire_x),
      .fire_y     (fire_y),
      .fire_dir   (fire_dir),
      .slot_kill  (slot_kill),
      .fire_grant (fire_grant),
      .fire_drop  (fire_drop),
      .slot_active(slot_active),
      .slot_x     (slot_x),
      .slot_y     (slot_y),
      .slot_dir   (slot_dir),
      .slot_owner (slot_owner)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick;
      @(posedge frame_clk);
      @(negedge frame_clk);
   endtask

   task automatic shot(input int i, input int x, input int y, input int d);
      fire_x[10*i+:10] = 10'(x);
      fire_y[10*i+:10] = 10'(y);
      fire_dir[2*i+:2] = 2'(d);
   endtask

   function automatic logic [31:0] sx(input int s);
      return 32'(slot_x[10*s+:10]);
   endfunction

   function automatic logic [31:0] sy(input int s);
      return 32'(slot_y[10*s+:10]);
   endfunction

   function automatic logic [31:0] sown(input int s);
      return 32'(slot_owner[2*s+:2]);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet;
      fire_req  = '0;
      fire_x    = '0;
      fire_y    = '0;
      fire_dir  = '0;
      slot_kill = '0;
      Reset     = 1'b1;
      tick;
      tick;
      check("rst_active", 32'(slot_active), 32'h0);
      check("rst_grant",  32'(fire_grant), 32'h0);
      check("rst_drop",   32'(fire_drop), 32'h0);
      check("rst_xy_zero", 32'((slot_x == '0) && (slot_y == '0) && (slot_owner == '0)), 32'd1);
      Reset = 1'b0;

      // single upward shot from the player, flown to the top edge
      shot(0, 320, 360, 0);
      fire_req = 4'b0001;
      tick;
      check("t1_grant",  32'(fire_grant), 32'h1);
      check("t1_active", 32'(slot_active), 32'h01);
      check("t1_x",      sx(0), 32'd320);
      check("t1_y_spawn", sy(0), 32'd360);
      fire_req = '0;
      tick;
      check("t1_y_move1", sy(0), 32'd358);
      check("t1_grant_pulse", 32'(fire_grant), 32'h0);
      repeat (179) tick;
      check("t1_y_zero",      sy(0), 32'd0);
      check("t1_still_alive", 32'(slot_active), 32'h01);
      tick;
      check("t1_retired",  32'(slot_active), 32'h00);
      check("t1_y_hold",   sy(0), 32'd0);

      // asynchronous reset with a bullet in flight
      shot(0, 100, 100, 1);
      fire_req = 4'b0001;
      tick;
      check("ar_alloc", 32'(slot_active), 32'h01);
      fire_req = '0;
      #2 Reset = 1'b1;
      #1;
      check("ar_cleared_active", 32'(slot_active), 32'h00);
      check("ar_cleared_x",      sx(0), 32'd0);
      @(negedge frame_clk);
      Reset = 1'b0;

      // all four request continuously: rotation, then cooldown, then pool full
      for (int i = 0; i < NREQ; i++) shot(i, 100 + 10*i, 100, 1);
      fire_req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick;
         check($sformatf("t2_rr_%0d", k), 32'(fire_grant), 32'(1 << k));
      end
      quiet = 0;
      repeat (27) begin
         tick;
         if (fire_grant != '0 || fire_drop != '0) quiet++;
      end
      check("t2_cooldown_quiet", 32'(quiet), 32'd0);
      tick;
      check("t2_regrant0", 32'(fire_grant), 32'h1);
      check("t2_regrant0_slot", 32'(slot_active), 32'h1F);
      tick;
      check("t2_regrant1", 32'(fire_grant), 32'h2);
      tick;
      tick;
      check("t2_regrant3", 32'(fire_grant), 32'h8);
      check("t2_pool_full", 32'(slot_active), 32'hFF);
      quiet = 0;
      repeat (27) begin
         tick;
         if (fire_grant != '0 || fire_drop != '0) quiet++;
      end
      check("t3_quiet", 32'(quiet), 32'd0);
      tick;
      check("t3_drop",     32'(fire_drop), 32'h1);
      check("t3_no_grant", 32'(fire_grant), 32'h0);
      tick;
      check("t3_drop_again", 32'(fire_drop), 32'h1);

      // kill slot 5 while full: drop this edge, reuse next edge
      slot_kill = 8'h20;
      tick;
      slot_kill = '0;
      check("t4_kill_active", 32'(slot_active), 32'hDF);
      check("t4_kill_drop",   32'(fire_drop), 32'h1);
      check("t4_kill_nogrant", 32'(fire_grant), 32'h0);
      check("t4_kill_y_hold", sy(5), 32'd162);
      tick;
      check("t4_reuse_grant", 32'(fire_grant), 32'h1);
      check("t4_reuse_active", 32'(slot_active), 32'hFF);
      check("t4_reuse_owner", sown(5), 32'd0);
      check("t4_reuse_y",     sy(5), 32'd100);
      tick;
      check("t4_rr_moved", 32'(fire_drop), 32'h2);

      // screen-edge retirement, right and bottom
      fire_req = '0;
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      shot(0, 638, 50, 3);
      fire_req = 4'b0001;
      tick;
      check("t5_right_alloc", 32'(slot_active), 32'h01);
      check("t5_right_x",     sx(0), 32'd638);
      shot(1, 10, 477, 1);
      fire_req = 4'b0010;
      tick;
      check("t5_right_retire", 32'(slot_active), 32'h02);
      check("t5_right_x_hold", sx(0), 32'd638);
      check("t5_down_grant",   32'(fire_grant), 32'h2);
      check("t5_down_owner",   sown(1), 32'd1);
      fire_req = '0;
      tick;
      check("t5_down_y479",  sy(1), 32'd479);
      check("t5_down_alive", 32'(slot_active), 32'h02);
      tick;
      check("t5_down_retire", 32'(slot_active), 32'h00);
      check("t5_down_y_hold", sy(1), 32'd479);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
